// File: rtl/warp_fetch.sv
// Instruction fetch front end: owns the fetch PC, issues aligned 8-byte imem reads
// and buffers returned two-instruction bundles in a FIFO presented to decode.
module warp_fetch #(
  parameter logic [38:0] RESET_ADDR = 39'h4000000000,
  parameter int          DEPTH      = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_ren,
  output logic [38:0] o_imem_raddr,
  input  logic        i_imem_valid,
  input  logic [63:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [38:0] i_redirect_pc,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [38:0] o_inst_pc,
  output logic [63:0] o_inst_data,
  output logic [1:0]  o_inst_mask
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e        state_q, state_d;
  logic [38:0]   fetch_pc_q, fetch_pc_d;
  logic          discard_q, discard_d;
  logic          offset_q, offset_d;
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q;

  logic [38:0]   pc_mem   [DEPTH];
  logic [63:0]   data_mem [DEPTH];
  logic [1:0]    mask_mem [DEPTH];

  logic empty, full, resp, push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign resp  = (state_q == WAIT) && i_imem_valid;
  // A redirect kills both the bundle arriving this cycle and the one leaving.
  assign push  = resp && !discard_q && !i_redirect;
  assign pop   = !empty && i_inst_ready && !i_redirect;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!i_redirect && !full) state_d = REQ;
      REQ:     state_d = WAIT;
      WAIT:    if (i_imem_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_imem_ren   = (state_q == REQ);
    o_imem_raddr = fetch_pc_q;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    offset_d   = offset_q;
    if (i_redirect) begin
      fetch_pc_d = {i_redirect_pc[38:3], 3'b000};
      offset_d   = i_redirect_pc[2];
      discard_d  = (state_q == REQ) || ((state_q == WAIT) && !i_imem_valid);
    end else if (resp) begin
      discard_d = 1'b0;
      if (!discard_q) begin
        fetch_pc_d = fetch_pc_q + 39'd8;
        offset_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fetch_pc_q <= RESET_ADDR;
      discard_q  <= 1'b0;
      offset_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
      offset_q   <= offset_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (i_redirect) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // NOTE: bundle storage has no reset; entries are only read once count marks them valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= offset_q ? {fetch_pc_q[38:3], 3'b100} : fetch_pc_q;
      data_mem[wr_ptr_q] <= i_imem_rdata;
      mask_mem[wr_ptr_q] <= offset_q ? 2'b10 : 2'b11;
    end
  end

  assign o_inst_valid = !empty;
  assign o_inst_pc    = pc_mem[rd_ptr_q];
  assign o_inst_data  = data_mem[rd_ptr_q];
  assign o_inst_mask  = mask_mem[rd_ptr_q];

endmodule

// File: tb/tb_warp_fetch.sv
// Bench for warp_fetch: transaction-level model of the fetch stream and bundle queue,
// a responding memory, and directed scenarios with literal expectations.
module tb_warp_fetch;

  localparam logic [38:0] RST_A = 39'h4000000000;
  localparam int          DEPTH = 4;

  logic        i_clk, i_rst;
  logic        o_imem_ren;
  logic [38:0] o_imem_raddr;
  logic        i_imem_valid;
  logic [63:0] i_imem_rdata;
  logic        i_redirect;
  logic [38:0] i_redirect_pc;
  logic        o_inst_valid;
  logic        i_inst_ready;
  logic [38:0] o_inst_pc;
  logic [63:0] o_inst_data;
  logic [1:0]  o_inst_mask;

  warp_fetch #(.RESET_ADDR(RST_A), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_imem_ren(o_imem_ren), .o_imem_raddr(o_imem_raddr),
    .i_imem_valid(i_imem_valid), .i_imem_rdata(i_imem_rdata),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_inst_valid(o_inst_valid), .i_inst_ready(i_inst_ready),
    .o_inst_pc(o_inst_pc), .o_inst_data(o_inst_data), .o_inst_mask(o_inst_mask)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct {
    logic [38:0] pc;
    logic [63:0] data;
    logic [1:0]  mask;
  } bundle_t;

  int total = 0;
  int bad   = 0;

  // Expected stream state
  bundle_t     q[$];
  logic [38:0] exp_addr = RST_A;
  logic        exp_off  = 1'b0;
  logic        outst    = 1'b0;
  logic        stale    = 1'b0;

  // Memory responder state
  logic        pend = 1'b0;
  logic [38:0] pend_addr;
  int          cnt;
  int          mem_lat = 1;
  int          inj_req = 0;
  int          inj_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [38:0] a);
    if (a == RST_A) return {32'h001000b3, 32'h00100133};
    return {a[31:0] ^ 32'h13579bdf, a[31:0] + 32'h0badf00d};
  endfunction

  always @(negedge i_clk) begin
    bundle_t b;
    if (i_rst) begin
      q.delete();
      exp_addr = RST_A; exp_off = 1'b0; outst = 1'b0; stale = 1'b0;
      pend = 1'b0; i_imem_valid = 1'b0;
      check("rst_ren", o_imem_ren, 0);
      check("rst_raddr", o_imem_raddr, RST_A);
      check("rst_valid", o_inst_valid, 0);
    end else begin
      check("inst_valid", o_inst_valid, q.size() != 0);
      if (q.size() != 0) begin
        check("head_pc", o_inst_pc, q[0].pc);
        check("head_data", o_inst_data, q[0].data);
        check("head_mask", o_inst_mask, q[0].mask);
      end
      if (o_imem_ren) begin
        check("ren_single", outst, 0);
        check("ren_notfull", q.size() < DEPTH, 1);
        check("raddr", o_imem_raddr, exp_addr);
      end
      i_imem_valid = 1'b0;
      if (inj_done != inj_req) begin
        i_imem_valid = 1'b1;
        i_imem_rdata = 64'hdeadbeef_badc0ffe;
        inj_done = inj_req;
      end else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          i_imem_valid = 1'b1;
          i_imem_rdata = mem_word(pend_addr);
          pend = 1'b0;
        end
      end
      if (o_imem_ren) begin
        pend = 1'b1; pend_addr = o_imem_raddr; cnt = mem_lat;
      end
      // Effect of the coming edge on the expected stream
      if (i_redirect) begin
        q.delete();
        if (outst && i_imem_valid) begin
          outst = 1'b0; stale = 1'b0;
        end else if (outst || o_imem_ren) begin
          outst = 1'b1; stale = 1'b1;
        end
        exp_addr = {i_redirect_pc[38:3], 3'b000};
        exp_off  = i_redirect_pc[2];
      end else begin
        if (q.size() != 0 && i_inst_ready) void'(q.pop_front());
        if (outst && i_imem_valid) begin
          outst = 1'b0;
          if (!stale) begin
            b.pc   = exp_off ? {exp_addr[38:3], 3'b100} : exp_addr;
            b.data = mem_word(exp_addr);
            b.mask = exp_off ? 2'b10 : 2'b11;
            q.push_back(b);
            exp_addr = exp_addr + 39'd8;
            exp_off  = 1'b0;
          end
          stale = 1'b0;
        end
        if (o_imem_ren) begin
          outst = 1'b1; stale = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_ren(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!o_imem_ren && n < 40);
    if (!o_imem_ren) check("ren_timeout", o_imem_ren, 1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!o_inst_valid && n < 40) begin
      step();
      n++;
    end
    if (!o_inst_valid) check("valid_timeout", o_inst_valid, 1);
  endtask

  task automatic wait_q(input int want);
    int n = 0;
    while (q.size() < want && n < 60) begin
      step();
      n++;
    end
    check("q_fill", q.size() >= want, 1);
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_redirect = 1'b0;
    step(); step();
    i_rst = 1'b0;
  endtask

  initial begin
    int n;
    int rens;
    i_rst = 1'b1; i_redirect = 1'b0; i_redirect_pc = '0;
    i_inst_ready = 1'b1; i_imem_valid = 1'b0; i_imem_rdata = '0;

    // First fetch after reset
    step(); step(); step();
    i_rst = 1'b0;
    wait_ren(n);
    check("first_ren_latency", n, 1);
    check("first_raddr", o_imem_raddr, RST_A);
    wait_valid();
    check("first_pc", o_inst_pc, RST_A);
    check("first_mask", o_inst_mask, 2'b11);
    check("first_data", o_inst_data, 64'h001000b3_00100133);
    wait_ren(n);
    check("second_raddr", o_imem_raddr, RST_A + 39'h8);

    // Fill to full with decode stalled, then free one slot
    do_reset();
    i_inst_ready = 1'b0;
    repeat (30) step();
    check("full_count", q.size(), 4);
    check("full_head_pc", o_inst_pc, RST_A);
    check("full_tail_pc", q[3].pc, RST_A + 39'h18);
    rens = 0;
    repeat (10) begin step(); rens += int'(o_imem_ren); end
    check("full_no_ren", rens, 0);
    i_inst_ready = 1'b1;
    step();
    i_inst_ready = 1'b0;
    wait_ren(n);
    check("refill_raddr", o_imem_raddr, RST_A + 39'h20);
    rens = 0;
    repeat (10) begin step(); rens += int'(o_imem_ren); end
    check("refill_single", rens, 0);

    // Redirect in WAIT with a slow, now-stale response
    do_reset();
    mem_lat = 3;
    wait_ren(n);
    step();
    i_redirect = 1'b1; i_redirect_pc = 39'h4000000104;
    step();
    i_redirect = 1'b0;
    wait_ren(n);
    check("redir_raddr", o_imem_raddr, 39'h4000000100);
    check("stale_dropped", o_inst_valid, 0);
    wait_valid();
    check("redir_pc", o_inst_pc, 39'h4000000104);
    check("redir_mask", o_inst_mask, 2'b10);
    repeat (15) step();
    i_inst_ready = 1'b1;
    step();
    i_inst_ready = 1'b0;
    check("redir_next_pc", o_inst_pc, 39'h4000000108);
    check("redir_next_mask", o_inst_mask, 2'b11);

    // Redirect coincident with response and pop, FIFO holding two
    do_reset();
    mem_lat = 1;
    wait_q(2);
    wait_ren(n);
    step();
    i_redirect = 1'b1; i_redirect_pc = 39'h4000000200; i_inst_ready = 1'b1;
    step();
    i_redirect = 1'b0; i_inst_ready = 1'b0;
    check("coinc_flush", o_inst_valid, 0);
    wait_ren(n);
    check("coinc_raddr", o_imem_raddr, 39'h4000000200);

    // Fetch PC wraps at the top of the address space
    do_reset();
    i_redirect = 1'b1; i_redirect_pc = 39'h7FFFFFFFF8;
    step();
    i_redirect = 1'b0;
    wait_ren(n);
    check("idle_redir_latency", n, 1);
    check("top_raddr", o_imem_raddr, 39'h7FFFFFFFF8);
    wait_ren(n);
    check("wrap_raddr", o_imem_raddr, 39'h0);
    check("top_pc", o_inst_pc, 39'h7FFFFFFFF8);
    check("top_mask", o_inst_mask, 2'b11);

    // Reset mid-WAIT with a non-empty FIFO, then a late response in IDLE
    do_reset();
    mem_lat = 3;
    wait_q(1);
    wait_ren(n);
    step();
    i_rst = 1'b1;
    #1;
    check("async_rst_valid", o_inst_valid, 0);
    check("async_rst_ren", o_imem_ren, 0);
    step(); step();
    i_rst = 1'b0;
    inj_req++;
    wait_ren(n);
    check("post_rst_latency", n, 1);
    check("post_rst_raddr", o_imem_raddr, RST_A);
    wait_valid();
    check("post_rst_pc", o_inst_pc, RST_A);
    check("post_rst_data", o_inst_data, 64'h001000b3_00100133);
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
